// File: rtl/test_end_monitor.sv
// End-of-test monitor: counts arrivals of the retiring PC at "tohost" watch
// addresses, then samples x3 into a sticky pass/fail verdict.
//
// Ports:
//   clk, rst_n (sync, active-low), clr_i (sync soft restart)
//   pc_valid_i, pc_i             retiring PC stream
//   watch_addr_i, watch_en_i     packed watch addresses + per-channel enables
//   result_i                     result register (x3)
//   done_o, pass_o, fail_o,
//   timeout_o, fail_code_o       sticky verdict and captured result
//   hit_cnt_o, hit_ch_o          arrival count, one-hot first-arrival channel
//   cycle_cnt_o, end_cycle_o     cycles since restart, cycle of first arrival
//
// Build option: define TEST_MON_TIMEOUT_EN to enable timeout detection on
// cycle_cnt_o[TIMEOUT_BIT]; otherwise timeout_o stays 0 and the cycle counter
// runs freely until completion.

module test_end_monitor #(
   parameter int          PC_WIDTH      = 32,
   parameter int          CNT_WIDTH     = 32,
   parameter int          NUM_WATCH     = 2,
   parameter int          HIT_THRESHOLD = 8,
   parameter int          TIMEOUT_BIT   = 20,
   parameter logic [31:0] PASS_VALUE    = 32'd1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr_i,
   input  logic                          pc_valid_i,
   input  logic [PC_WIDTH-1:0]           pc_i,
   input  logic [NUM_WATCH*PC_WIDTH-1:0] watch_addr_i,
   input  logic [NUM_WATCH-1:0]          watch_en_i,
   input  logic [31:0]                   result_i,
   output logic                          done_o,
   output logic                          pass_o,
   output logic                          fail_o,
   output logic                          timeout_o,
   output logic [31:0]                   fail_code_o,
   output logic [7:0]                    hit_cnt_o,
   output logic [NUM_WATCH-1:0]          hit_ch_o,
   output logic [CNT_WIDTH-1:0]          cycle_cnt_o,
   output logic [CNT_WIDTH-1:0]          end_cycle_o
);

   typedef enum logic [1:0] {
      S_RUN,
      S_ARMED,
      S_DONE,
      S_TOUT
   } state_t;

`ifdef TEST_MON_TIMEOUT_EN
   localparam logic TMO_EN = 1'b1;
`else
   localparam logic TMO_EN = 1'b0;
`endif

   localparam logic [7:0]           THR     = 8'(HIT_THRESHOLD);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t                state;
   logic [PC_WIDTH-1:0]   last_pc;
   logic                  last_vld;
   logic                  match;
   logic [NUM_WATCH-1:0]  first_ch;
   logic                  arrival;
   logic                  tmo;
   logic                  complete;

   // Descending scan so the lowest matching channel wins the one-hot code.
   always_comb begin
      match    = 1'b0;
      first_ch = '0;
      for (int k = NUM_WATCH - 1; k >= 0; k--) begin
         if (watch_en_i[k] &&
             pc_i == watch_addr_i[k*PC_WIDTH +: PC_WIDTH]) begin
            match       = 1'b1;
            first_ch    = '0;
            first_ch[k] = 1'b1;
         end
      end
   end

   // A PC dwelling on a watch address counts once.
   assign arrival  = pc_valid_i && match &&
                     (!last_vld || pc_i != last_pc);
   assign complete = arrival && (hit_cnt_o + 8'd1 == THR);
   assign tmo      = TMO_EN && cycle_cnt_o[TIMEOUT_BIT];

   always_ff @(posedge clk) begin
      if (!rst_n || clr_i) begin
         state       <= S_RUN;
         last_pc     <= '0;
         last_vld    <= 1'b0;
         done_o      <= 1'b0;
         pass_o      <= 1'b0;
         fail_o      <= 1'b0;
         timeout_o   <= 1'b0;
         fail_code_o <= '0;
         hit_cnt_o   <= '0;
         hit_ch_o    <= '0;
         cycle_cnt_o <= '0;
         end_cycle_o <= '0;
      end else begin
         if (pc_valid_i) begin
            last_pc  <= pc_i;
            last_vld <= 1'b1;
         end
         unique case (state)
            S_RUN, S_ARMED: begin
               if (complete || !tmo) begin
                  if (arrival && state == S_RUN) begin
                     end_cycle_o <= cycle_cnt_o;
                     hit_ch_o    <= first_ch;
                  end
               end
               // Completion outranks a coincident timeout.
               if (complete) begin
                  state       <= S_DONE;
                  done_o      <= 1'b1;
                  hit_cnt_o   <= hit_cnt_o + 8'd1;
                  fail_code_o <= result_i;
                  pass_o      <= (result_i == PASS_VALUE);
                  fail_o      <= (result_i != PASS_VALUE);
               end else if (tmo) begin
                  state     <= S_TOUT;
                  done_o    <= 1'b1;
                  timeout_o <= 1'b1;
               end else begin
                  cycle_cnt_o <= cycle_cnt_o + CNT_ONE;
                  if (arrival) begin
                     hit_cnt_o <= hit_cnt_o + 8'd1;
                     state     <= S_ARMED;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
